// File: rtl/backtrack_ctrl.sv
// backtrack_ctrl -- trace-table sequencer for the DPLL solver core.
//
// In normal search it forwards decide / imply requests onto the trace stack
// as typed entries (type 0 = Decide, 1 = Forced). On a conflict it unwinds
// the trace down to and including the most recent Decide entry. It emits an
// unassign for every popped variable. It then re-pushes the decided variable
// as a Forced entry with the opposite value. A conflict with no open decision
// is reported as a sticky UNSAT. Only reset leaves UNSAT.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   dec_valid, imp_valid  decide / implied-assignment requests
//   req_val, req_var      requested assignment
//   req_ready             request accepted this cycle (combinational)
//   conflict              BCP conflict, sampled in IDLE only
//   tr_push, tr_pop       trace stack strobes
//   tr_type_in/val_in/var_in     entry being pushed
//   tr_type_out/val_out/var_out  top entry, valid together with tr_pop
//   tr_empty, tr_full     trace stack status
//   unassign_valid/var    clear a variable in the assignment memory
//   flip_valid/var/val    write the flipped assignment
//   busy, bt_done, unsat  status
//   decision_level        Decide entries currently on the trace
//   last_depth            pops performed by the most recent backtrack

`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif
`ifndef MAX_VARS
`define MAX_VARS 256
`endif

module backtrack_ctrl #(
   parameter int VAR_BITS = `MAX_VARS_BITS,
   parameter int DEPTH    = `MAX_VARS,
   localparam int CW      = $clog2(DEPTH) + 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                dec_valid,
   input  logic                imp_valid,
   input  logic                req_val,
   input  logic [VAR_BITS-1:0] req_var,
   output logic                req_ready,
   input  logic                conflict,
   output logic                tr_push,
   output logic                tr_pop,
   output logic                tr_type_in,
   output logic                tr_val_in,
   output logic [VAR_BITS-1:0] tr_var_in,
   input  logic                tr_type_out,
   input  logic                tr_val_out,
   input  logic [VAR_BITS-1:0] tr_var_out,
   input  logic                tr_empty,
   input  logic                tr_full,
   output logic                unassign_valid,
   output logic [VAR_BITS-1:0] unassign_var,
   output logic                flip_valid,
   output logic [VAR_BITS-1:0] flip_var,
   output logic                flip_val,
   output logic                busy,
   output logic                bt_done,
   output logic                unsat,
   output logic [CW-1:0]       decision_level,
   output logic [CW-1:0]       last_depth
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BT_POP = 2'd1,
      S_FLIP   = 2'd2,
      S_UNSAT  = 2'd3
   } state_t;

   state_t              state, state_nx;
   logic [CW-1:0]       level_nx;
   logic [CW-1:0]       depth_cnt, depth_nx;
   logic [CW-1:0]       last_depth_nx;
   logic [VAR_BITS-1:0] flip_var_q, flip_var_nx;
   logic                flip_val_q, flip_val_nx;

   // Counters hold at their limits instead of wrapping.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
      return (x >= CW'(DEPTH)) ? x : x + 1'b1;
   endfunction

   function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] x);
      return (x == '0) ? x : x - 1'b1;
   endfunction

   always_comb begin
      state_nx       = state;
      level_nx       = decision_level;
      depth_nx       = depth_cnt;
      last_depth_nx  = last_depth;
      flip_var_nx    = flip_var_q;
      flip_val_nx    = flip_val_q;
      req_ready      = 1'b0;
      tr_push        = 1'b0;
      tr_pop         = 1'b0;
      tr_type_in     = 1'b0;
      tr_val_in      = 1'b0;
      tr_var_in      = '0;
      unassign_valid = 1'b0;
      unassign_var   = '0;
      flip_valid     = 1'b0;
      flip_var       = '0;
      flip_val       = 1'b0;
      busy           = 1'b0;
      bt_done        = 1'b0;
      unsat          = 1'b0;

      // The strobes are combinational. Gating them here keeps every output
      // low while reset is held, even though a request may be pending.
      if (!reset) begin
         unique case (state)
            S_IDLE: begin
               if (conflict) begin
                  if (decision_level == '0) begin
                     state_nx = S_UNSAT;
                  end else begin
                     depth_nx = '0;
                     state_nx = S_BT_POP;
                  end
               end else if (!tr_full && (dec_valid || imp_valid)) begin
                  // An implied assignment wins over a decide and is pushed as Forced.
                  req_ready  = 1'b1;
                  tr_push    = 1'b1;
                  tr_type_in = imp_valid;
                  tr_val_in  = req_val;
                  tr_var_in  = req_var;
                  if (!imp_valid) level_nx = sat_inc(decision_level);
               end
            end

            S_BT_POP: begin
               busy = 1'b1;
               if (tr_empty) begin
                  state_nx = S_UNSAT;
               end else begin
                  tr_pop         = 1'b1;
                  unassign_valid = 1'b1;
                  unassign_var   = tr_var_out;
                  depth_nx       = sat_inc(depth_cnt);
                  if (!tr_type_out) begin
                     flip_var_nx = tr_var_out;
                     flip_val_nx = ~tr_val_out;
                     level_nx    = sat_dec(decision_level);
                     state_nx    = S_FLIP;
                  end
               end
            end

            S_FLIP: begin
               // The Decide entry was just popped, so this push always has room.
               busy          = 1'b1;
               tr_push       = 1'b1;
               tr_type_in    = 1'b1;
               tr_val_in     = flip_val_q;
               tr_var_in     = flip_var_q;
               flip_valid    = 1'b1;
               flip_var      = flip_var_q;
               flip_val      = flip_val_q;
               bt_done       = 1'b1;
               last_depth_nx = depth_cnt;
               state_nx      = S_IDLE;
            end

            S_UNSAT: begin
               busy  = 1'b1;
               unsat = 1'b1;
            end

            default: state_nx = S_IDLE;
         endcase
      end
   end

   // Control state: asynchronous reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         decision_level <= '0;
         depth_cnt      <= '0;
         last_depth     <= '0;
      end else begin
         state          <= state_nx;
         decision_level <= level_nx;
         depth_cnt      <= depth_nx;
         last_depth     <= last_depth_nx;
      end
   end

   // Latched flip assignment: data only, not reset
   always_ff @(posedge clock) begin
      flip_var_q <= flip_var_nx;
      flip_val_q <= flip_val_nx;
   end

endmodule

// File: tb/tb_backtrack_ctrl.sv
// Testbench for backtrack_ctrl. It contains a behavioural trace stack and a
// list-based reference model of the solver trace. Expected pushes, unassigns
// and flips go into queues. A monitor process pops those queues and compares
// them against the DUT on every falling edge.

module tb_backtrack_ctrl;

   localparam int VB    = 4;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic          typ;
      logic          val;
      logic [VB-1:0] v;
   } ent_t;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          dec_valid = 1'b0, imp_valid = 1'b0, req_val = 1'b0, conflict = 1'b0;
   logic [VB-1:0] req_var = '0;
   logic          req_ready, tr_push, tr_pop, tr_type_in, tr_val_in;
   logic [VB-1:0] tr_var_in, tr_var_out, unassign_var, flip_var;
   logic          tr_type_out, tr_val_out, tr_empty, tr_full;
   logic          unassign_valid, flip_valid, flip_val, busy, bt_done, unsat;
   logic [CW-1:0] decision_level, last_depth;

   int n_checks = 0;
   int n_errors = 0;
   int pop_cnt  = 0;
   int done_cnt = 0;

   ent_t          mtr[$];
   ent_t          exp_push[$];
   ent_t          exp_flip[$];
   logic [VB-1:0] exp_un[$];

   always #5 clock = ~clock;

   backtrack_ctrl #(.VAR_BITS(VB), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .dec_valid(dec_valid), .imp_valid(imp_valid),
      .req_val(req_val), .req_var(req_var), .req_ready(req_ready),
      .conflict(conflict),
      .tr_push(tr_push), .tr_pop(tr_pop),
      .tr_type_in(tr_type_in), .tr_val_in(tr_val_in), .tr_var_in(tr_var_in),
      .tr_type_out(tr_type_out), .tr_val_out(tr_val_out), .tr_var_out(tr_var_out),
      .tr_empty(tr_empty), .tr_full(tr_full),
      .unassign_valid(unassign_valid), .unassign_var(unassign_var),
      .flip_valid(flip_valid), .flip_var(flip_var), .flip_val(flip_val),
      .busy(busy), .bt_done(bt_done), .unsat(unsat),
      .decision_level(decision_level), .last_depth(last_depth)
   );

   // Behavioural trace stack. Strobes are captured mid-cycle and applied at the edge.
   logic          s_typ [DEPTH];
   logic          s_val [DEPTH];
   logic [VB-1:0] s_var [DEPTH];
   int            sp;
   logic          p_push = 1'b0, p_pop = 1'b0;
   ent_t          p_ent;

   assign tr_empty    = (sp == 0);
   assign tr_full     = (sp == DEPTH);
   assign tr_type_out = (sp > 0) ? s_typ[sp-1] : 1'b0;
   assign tr_val_out  = (sp > 0) ? s_val[sp-1] : 1'b0;
   assign tr_var_out  = (sp > 0) ? s_var[sp-1] : '0;

   always @(negedge clock) begin
      p_push <= tr_push;
      p_pop  <= tr_pop;
      p_ent  <= '{typ: tr_type_in, val: tr_val_in, v: tr_var_in};
   end

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         sp <= 0;
      end else if (p_pop && p_push && sp > 0) begin
         s_typ[sp-1] <= p_ent.typ;
         s_val[sp-1] <= p_ent.val;
         s_var[sp-1] <= p_ent.v;
      end else if (p_pop && sp > 0) begin
         sp <= sp - 1;
      end else if (p_push && sp < DEPTH) begin
         s_typ[sp] <= p_ent.typ;
         s_val[sp] <= p_ent.val;
         s_var[sp] <= p_ent.v;
         sp        <= sp + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: unexpected DUT activity at %0t", name, $time);
   endtask

   // Reference model: the decision level is the number of Decide entries on the trace.
   function automatic int model_level();
      int n = 0;
      foreach (mtr[i]) if (mtr[i].typ == 1'b0) n++;
      return n;
   endfunction

   // Unwind the model trace to the newest Decide entry, then append its flip.
   // The return value is the number of pops.
   function automatic int model_bt();
      ent_t e;
      ent_t f;
      int   k = 0;
      do begin
         e = mtr.pop_back();
         exp_un.push_back(e.v);
         k++;
      end while (e.typ != 1'b0);
      f = '{typ: 1'b1, val: ~e.val, v: e.v};
      exp_flip.push_back(f);
      exp_push.push_back(f);
      mtr.push_back(f);
      return k;
   endfunction

   // Monitor / scoreboard
   initial begin
      ent_t          e;
      logic [VB-1:0] v;
      forever begin
         @(negedge clock);
         if (!reset) begin
            if (tr_push) begin
               if (exp_push.size() == 0) fail_now("unexpected_push");
               else begin
                  e = exp_push.pop_front();
                  chk("push_type", tr_type_in, e.typ);
                  chk("push_val", tr_val_in, e.val);
                  chk("push_var", tr_var_in, e.v);
               end
            end
            if (tr_pop || unassign_valid) begin
               pop_cnt++;
               if (exp_un.size() == 0) fail_now("unexpected_pop");
               else begin
                  v = exp_un.pop_front();
                  chk("unassign_var", unassign_var, v);
                  chk("pop_and_unassign", {tr_pop, unassign_valid}, 2'b11);
               end
            end
            if (flip_valid || bt_done) begin
               done_cnt++;
               if (exp_flip.size() == 0) fail_now("unexpected_flip");
               else begin
                  e = exp_flip.pop_front();
                  chk("flip_var", flip_var, e.v);
                  chk("flip_val", flip_val, e.val);
                  chk("flip_and_done", {flip_valid, bt_done}, 2'b11);
               end
            end
         end
      end
   end

   // Drive one request starting just after a rising edge and return just after the next one.
   task automatic issue_req(input bit imp, input bit val, input logic [VB-1:0] v);
      bit   will;
      ent_t e;
      will      = (mtr.size() < DEPTH);
      dec_valid = !imp;
      imp_valid = imp;
      req_val   = val;
      req_var   = v;
      if (will) begin
         e = '{typ: imp, val: val, v: v};
         exp_push.push_back(e);
         mtr.push_back(e);
      end
      @(negedge clock);
      chk("req_ready", req_ready, will);
      if (!will) chk("push_while_full", tr_push, 1'b0);
      @(posedge clock); #1;
      dec_valid = 1'b0;
      imp_valid = 1'b0;
      chk("decision_level", decision_level, model_level());
   endtask

   task automatic do_conflict(input bit with_req);
      int lvl, k, cnt, d0;
      lvl      = model_level();
      d0       = done_cnt;
      k        = 0;
      conflict = 1'b1;
      if (with_req) begin
         imp_valid = 1'b1;
         req_val   = 1'($urandom);
         req_var   = VB'($urandom);
      end
      if (lvl > 0) k = model_bt();
      @(negedge clock);
      chk("ready_on_conflict", req_ready, 1'b0);
      @(posedge clock); #1;
      conflict  = 1'b0;
      imp_valid = 1'b0;
      if (lvl == 0) begin
         chk("unsat_next_cycle", {unsat, busy}, 2'b11);
      end else begin
         chk("busy_after_conflict", busy, 1'b1);
         cnt = 0;
         while (busy && cnt < 200) begin
            @(posedge clock); #1;
            cnt++;
         end
         chk("bt_latency", cnt, k + 1);
         chk("last_depth", last_depth, k);
         chk("level_after_bt", decision_level, model_level());
         chk("bt_done_once", done_cnt - d0, 1);
         chk("unassign_drained", exp_un.size(), 0);
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      dec_valid = 1'b0;
      imp_valid = 1'b0;
      conflict  = 1'b0;
      mtr.delete();
      exp_push.delete();
      exp_flip.delete();
      exp_un.delete();
      @(posedge clock); #1;
      reset = 1'b0;
      chk("idle_after_reset", busy, 1'b0);
      chk("level_after_reset", decision_level, 0);
   endtask

   initial begin
      int pc;
      int r;
      // Reset with requests pending: every output must stay low.
      dec_valid = 1'b1;
      imp_valid = 1'b1;
      @(posedge clock); @(posedge clock); #1;
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_push", tr_push, 1'b0);
      chk("rst_busy_unsat", {busy, unsat, bt_done, tr_pop}, 4'b0);
      chk("rst_level", decision_level, 0);
      chk("rst_last_depth", last_depth, 0);
      dec_valid = 1'b0;
      imp_valid = 1'b0;
      reset     = 1'b0;
      @(posedge clock); #1;

      // Nested backtrack, single conflict
      issue_req(1'b0, 1'b1, 4'd3);
      issue_req(1'b1, 1'b0, 4'd5);
      issue_req(1'b1, 1'b1, 4'd7);
      chk("level_one", decision_level, 1);
      do_conflict(1'b0);
      chk("scn1_last_depth", last_depth, 3);
      chk("scn1_level", decision_level, 0);

      // Nested decisions
      issue_req(1'b0, 1'b0, 4'd10);
      issue_req(1'b0, 1'b1, 4'd11);
      chk("level_two", decision_level, 2);
      do_conflict(1'b0);
      chk("nest_depth1", last_depth, 1);
      do_conflict(1'b0);
      chk("nest_depth2", last_depth, 2);
      chk("nest_level0", decision_level, 0);

      // Conflict and request together
      issue_req(1'b0, 1'b1, 4'd2);
      do_conflict(1'b1);

      // Fill the trace, then a decide must be refused
      issue_req(1'b0, 1'b0, 4'd6);
      while (mtr.size() < DEPTH) issue_req(1'($urandom), 1'($urandom), VB'($urandom));
      chk("trace_full", tr_full, 1'b1);
      issue_req(1'b0, 1'b1, 4'd9);
      do_conflict(1'b0);

      // Randomized traffic, kept away from level-0 conflicts
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 9);
         if (r < 2 && model_level() > 0) do_conflict(r == 0);
         else if (mtr.size() == DEPTH && model_level() == 0) do_reset();
         else issue_req(r > 6, 1'($urandom), VB'($urandom));
      end

      // Reset in the middle of a backtrack
      do_reset();
      issue_req(1'b0, 1'b1, 4'd9);
      issue_req(1'b1, 1'b0, 4'd10);
      issue_req(1'b1, 1'b1, 4'd11);
      issue_req(1'b1, 1'b0, 4'd12);
      conflict = 1'b1;
      void'(model_bt());
      @(posedge clock); #1;
      conflict = 1'b0;
      @(posedge clock); #1;
      chk("mid_bt_popping", {busy, tr_pop}, 2'b11);
      reset = 1'b1;
      #1;
      chk("rst_drop", {busy, tr_pop, unassign_valid}, 3'b000);
      @(posedge clock); #1;
      do_reset();
      issue_req(1'b0, 1'b0, 4'd4);
      do_conflict(1'b0);

      // Conflict at level 0 ends in UNSAT
      do_reset();
      issue_req(1'b1, 1'b1, 4'd1);
      issue_req(1'b1, 1'b0, 4'd2);
      pc = pop_cnt;
      do_conflict(1'b0);
      dec_valid = 1'b1;
      imp_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("unsat_no_ready", req_ready, 1'b0);
      end
      @(posedge clock); #1;
      dec_valid = 1'b0;
      imp_valid = 1'b0;
      chk("unsat_sticky", unsat, 1'b1);
      chk("unsat_no_pops", pop_cnt - pc, 0);
      chk("push_drained", exp_push.size(), 0);
      chk("flip_drained", exp_flip.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
